// File: rtl/btn_sched_pkg.sv
// btn_sched_pkg: event codes, press FSM states and counter width
// shared by btn_event_sched and btn_press_fsm.
package btn_sched_pkg;

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    EVT_SHORT  = 2'b00,
    EVT_LONG   = 2'b01,
    EVT_REPEAT = 2'b10
  } evt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRESS = 2'b01,
    HELD  = 2'b10
  } fsm_t;

endpackage

// File: rtl/btn_event_sched_if.sv
// btn_event_sched_if: event channel from the scheduler to the
// watch mode FSM (valid/ready plus overwrite pulse).
interface btn_event_sched_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_btn;
  logic [1:0] evt_type;
  logic       evt_drop;

  modport master (
    output evt_valid,
    output evt_btn,
    output evt_type,
    output evt_drop,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_btn,
    input  evt_type,
    input  evt_drop,
    output evt_ready
  );
endinterface

// File: rtl/btn_press_fsm.sv
// btn_press_fsm: per-button press classifier with 11-bit hold counter.
// Auto-repeat while held is built only with BTN_REPEAT_EN defined.
module btn_press_fsm
  import btn_sched_pkg::*;
#(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic reset_p,
  input  logic tick_i,
  input  logic pedge_i,
  input  logic nedge_i,
  output logic post_o,
  output evt_t type_o
);

  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_MS);
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_C = CNT_W'(REPEAT_MS);
`endif

  if (LONG_MS < 1 || LONG_MS > 2047 ||
      REPEAT_MS < 1 || REPEAT_MS > 2047) begin : g_bad_cfg
    $error("btn_press_fsm: LONG_MS/REPEAT_MS out of 1..2047");
  end

  fsm_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  // saturating increment
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    post_o  = 1'b0;
    type_o  = EVT_SHORT;
    if (pedge_i) begin
      if (!nedge_i) begin
        state_d = PRESS;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        PRESS: begin
          if (nedge_i) begin
            post_o  = 1'b1;
            state_d = IDLE;
          end else if (tick_i) begin
            if (cnt_inc == LONG_C) begin
              post_o  = 1'b1;
              type_o  = EVT_LONG;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        HELD: begin
          if (nedge_i) begin
            state_d = IDLE;
          end
`ifdef BTN_REPEAT_EN
          else if (tick_i) begin
            if (cnt_inc == REP_C) begin
              post_o = 1'b1;
              type_o = EVT_REPEAT;
              cnt_d  = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/btn_event_sched.sv
// btn_event_sched: per-button pending slots, round-robin arbiter and
// 1-entry output register; BTN_REPEAT_EN enables REPEAT events.
module btn_event_sched
  import btn_sched_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             tick_ms,
  input  logic [N_BTN-1:0] btn_pedge,
  input  logic [N_BTN-1:0] btn_nedge,
  btn_event_sched_if.master evt
);

  localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  if (N_BTN < 2 || N_BTN > 8) begin : g_bad_cfg
    $error("btn_event_sched: N_BTN out of 2..8");
  end

  logic [N_BTN-1:0]      post;
  logic [N_BTN-1:0][1:0] ptype;
  logic [N_BTN-1:0]      full_q, full_d;
  logic [N_BTN-1:0][1:0] slot_q, slot_d;
  logic [IDX_W-1:0]      rr_q, gnt_idx;
  logic                  gnt_vld, grant;
  logic                  vld_q, drop_q, drop_d;
  logic [2:0]            btn_q;
  evt_t                  type_q;
  int                    j;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_press_fsm #(
      .LONG_MS   (LONG_MS),
      .REPEAT_MS (REPEAT_MS)
    ) u_fsm (
      .clk     (clk),
      .reset_p (reset_p),
      .tick_i  (tick_ms),
      .pedge_i (btn_pedge[g]),
      .nedge_i (btn_nedge[g]),
      .post_o  (post[g]),
      .type_o  (ptype[g])
    );
  end

  // first full slot after the last granted one
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 1; k <= N_BTN; k++) begin
      j = int'(rr_q) + k;
      if (j >= N_BTN) j = j - N_BTN;
      if (!gnt_vld && full_q[IDX_W'(j)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  assign grant = gnt_vld && (!vld_q || evt.evt_ready);

  // a post racing a grant on the same slot refills it, no drop
  always_comb begin
    full_d = full_q;
    slot_d = slot_q;
    drop_d = 1'b0;
    if (grant) full_d[gnt_idx] = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (post[i]) begin
        if (full_q[i] && !(grant && gnt_idx == IDX_W'(i)))
          drop_d = 1'b1;
        full_d[i] = 1'b1;
        slot_d[i] = ptype[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      full_q <= '0;
      slot_q <= '0;
      rr_q   <= '0;
      vld_q  <= 1'b0;
      btn_q  <= '0;
      type_q <= EVT_SHORT;
      drop_q <= 1'b0;
    end else begin
      full_q <= full_d;
      slot_q <= slot_d;
      drop_q <= drop_d;
      if (grant) begin
        vld_q  <= 1'b1;
        btn_q  <= 3'(gnt_idx);
        type_q <= evt_t'(slot_q[gnt_idx]);
        rr_q   <= gnt_idx;
      end else if (evt.evt_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = vld_q;
  assign evt.evt_btn   = btn_q;
  assign evt.evt_type  = type_q;
  assign evt.evt_drop  = drop_q;

endmodule
